// File: rtl/motor_cmd_scheduler.sv
// motor_cmd_scheduler
// Sits between the UART command parser and the per-channel step generators.
// Each channel owns one shadow command slot. A slot is copied into the motor
// controller registers only once that controller is idle. Moves heading into
// an active endstop are aborted. Per-channel status is exported for reporting.

module motor_cmd_scheduler #(
  parameter int NUM_CH   = 10,
  parameter int DIV_W    = 16,
  parameter int STEP_W   = 11,
  parameter bit HOME_DIR = 1'b0,
  parameter int START_TO = 16
) (
  input  logic                     CLOCK_25,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_ch,
  input  logic [DIV_W-1:0]         cmd_div,
  input  logic [STEP_W-1:0]        cmd_steps,
  input  logic                     cmd_dir,
  output logic                     cmd_err,
  input  logic [NUM_CH-1:0]        mr_active,
  input  logic [NUM_CH-1:0]        term_n,
  output logic [NUM_CH*DIV_W-1:0]  mr_divider,
  output logic [NUM_CH*STEP_W-1:0] mr_steps,
  output logic [NUM_CH-1:0]        mr_dir,
  output logic [NUM_CH-1:0]        mr_reset,
  output logic [NUM_CH-1:0]        pending,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        aborted,
  output logic [NUM_CH-1:0]        fault
);

  localparam int TMR_W = (START_TO < 1) ? 1 : $clog2(START_TO + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(START_TO);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [4:0]       NUM_CH_L = 5'(NUM_CH);

  // Endstop synchronizer
  logic [NUM_CH-1:0] termS1_q, termS2_q;
  logic [NUM_CH-1:0] hit;

  // Per-channel status and controller-facing registers
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [NUM_CH-1:0] aborted_q, aborted_d;
  logic [NUM_CH-1:0] fault_q, fault_d;
  logic [NUM_CH-1:0] mrReset_q, mrReset_d;
  logic [NUM_CH-1:0] mrDir_q, mrDir_d;
  logic [NUM_CH-1:0] activePrev_q;
  logic [NUM_CH-1:0] seenActive_q, seenActive_d;
  logic [NUM_CH-1:0] shDir_q, shDir_d;

  logic [DIV_W-1:0]  shDiv_q    [NUM_CH];
  logic [DIV_W-1:0]  shDiv_d    [NUM_CH];
  logic [STEP_W-1:0] shSteps_q  [NUM_CH];
  logic [STEP_W-1:0] shSteps_d  [NUM_CH];
  logic [DIV_W-1:0]  mrDiv_q    [NUM_CH];
  logic [DIV_W-1:0]  mrDiv_d    [NUM_CH];
  logic [STEP_W-1:0] mrSteps_q  [NUM_CH];
  logic [STEP_W-1:0] mrSteps_d  [NUM_CH];
  logic [TMR_W-1:0]  timer_q    [NUM_CH];
  logic [TMR_W-1:0]  timer_d    [NUM_CH];

  logic [3:0] rrPtr_q, rrPtr_d;
  logic       cmdErr_q, cmdErr_d;

  // Command handshake decode
  logic [15:0]       pendPad;
  logic              chInRange;
  logic              cmdBad;
  logic              accept;
  logic              acceptOk;
  logic [NUM_CH-1:0] acceptVec;

  // Arbitration and per-channel events
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grantVec;
  logic              grantAny;
  logic [3:0]        grantIdx;
  logic [3:0]        cand;
  logic [NUM_CH-1:0] abortEv;
  logic [NUM_CH-1:0] doneEv;
  logic [NUM_CH-1:0] timeoutEv;

  // Channel index base+k, wrapped into 0..NUM_CH-1.
  function automatic logic [3:0] wrapIdx(input logic [3:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return 4'(s);
  endfunction

  assign hit       = ~termS2_q;
  assign pendPad   = 16'(pending_q);
  assign chInRange = ({1'b0, cmd_ch} < NUM_CH_L);
  assign cmd_ready = ~chInRange | ~pendPad[cmd_ch];
  assign cmdBad    = ~chInRange | (cmd_steps == '0);
  assign accept    = cmd_valid & cmd_ready;
  assign acceptOk  = accept & ~cmdBad;
  assign eligible  = pending_q & ~busy_q & ~mr_active;

  // Two-flop synchronizer for the asynchronous endstop inputs
  always_ff @(posedge CLOCK_25 or negedge rst_n) begin
    if (!rst_n) begin
      termS1_q <= '0;
      termS2_q <= '0;
    end else begin
      termS1_q <= term_n;
      termS2_q <= termS1_q;
    end
  end

  // Decode a valid accept into a one-hot channel select
  always_comb begin
    acceptVec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      acceptVec[i] = acceptOk & (cmd_ch == 4'(i));
    end
  end

  // Round-robin search over eligible channels starting at the pointer
  always_comb begin
    grantAny = 1'b0;
    grantIdx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = wrapIdx(rrPtr_q, k);
      if (!grantAny && eligible[cand]) begin
        grantAny = 1'b1;
        grantIdx = cand;
      end
    end
  end

  // Expand the winning index into a one-hot grant
  always_comb begin
    grantVec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grantVec[i] = grantAny & (grantIdx == 4'(i));
    end
  end

  // Busy-channel events; abort outranks done, done outranks timeout
  always_comb begin
    abortEv   = '0;
    doneEv    = '0;
    timeoutEv = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      abortEv[i]   = busy_q[i] & hit[i] & (mrDir_q[i] == HOME_DIR);
      doneEv[i]    = busy_q[i] & ~abortEv[i] & activePrev_q[i] & ~mr_active[i];
      timeoutEv[i] = busy_q[i] & ~abortEv[i] & ~doneEv[i] & ~seenActive_q[i] &
                     ~mr_active[i] & (timer_q[i] <= TMR_ONE);
    end
  end

  // Next-state for all channel state; an accept is applied last so it wins
  always_comb begin
    pending_d    = pending_q;
    busy_d       = busy_q;
    aborted_d    = aborted_q;
    fault_d      = fault_q;
    mrReset_d    = '0;
    mrDir_d      = mrDir_q;
    seenActive_d = seenActive_q;
    shDir_d      = shDir_q;
    shDiv_d      = shDiv_q;
    shSteps_d    = shSteps_q;
    mrDiv_d      = mrDiv_q;
    mrSteps_d    = mrSteps_q;
    timer_d      = timer_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (busy_q[i] && (timer_q[i] != '0)) begin
        timer_d[i] = timer_q[i] - TMR_ONE;
      end
      if (busy_q[i] && mr_active[i]) begin
        seenActive_d[i] = 1'b1;
      end
      if (abortEv[i]) begin
        mrReset_d[i] = 1'b1;
        mrSteps_d[i] = '0;
        busy_d[i]    = 1'b0;
        pending_d[i] = 1'b0;
        aborted_d[i] = 1'b1;
      end else if (doneEv[i]) begin
        mrSteps_d[i] = '0;
        busy_d[i]    = 1'b0;
      end else if (timeoutEv[i]) begin
        mrSteps_d[i] = '0;
        busy_d[i]    = 1'b0;
        fault_d[i]   = 1'b1;
      end
      if (grantVec[i]) begin
        mrDiv_d[i]      = shDiv_q[i];
        mrSteps_d[i]    = shSteps_q[i];
        mrDir_d[i]      = shDir_q[i];
        pending_d[i]    = 1'b0;
        busy_d[i]       = 1'b1;
        timer_d[i]      = TMR_LOAD;
        seenActive_d[i] = 1'b0;
      end
      if (acceptVec[i]) begin
        shDiv_d[i]   = cmd_div;
        shSteps_d[i] = cmd_steps;
        shDir_d[i]   = cmd_dir;
        pending_d[i] = 1'b1;
        aborted_d[i] = 1'b0;
        fault_d[i]   = 1'b0;
      end
    end
    rrPtr_d  = grantAny ? wrapIdx(grantIdx, 1) : rrPtr_q;
    cmdErr_d = accept & cmdBad;
  end

  // State registers; reset returns every channel to idle with zero steps
  always_ff @(posedge CLOCK_25 or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      busy_q       <= '0;
      aborted_q    <= '0;
      fault_q      <= '0;
      mrReset_q    <= '0;
      mrDir_q      <= '0;
      activePrev_q <= '0;
      seenActive_q <= '0;
      shDir_q      <= '0;
      rrPtr_q      <= '0;
      cmdErr_q     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shDiv_q[i]   <= '0;
        shSteps_q[i] <= '0;
        mrDiv_q[i]   <= '0;
        mrSteps_q[i] <= '0;
        timer_q[i]   <= '0;
      end
    end else begin
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      aborted_q    <= aborted_d;
      fault_q      <= fault_d;
      mrReset_q    <= mrReset_d;
      mrDir_q      <= mrDir_d;
      activePrev_q <= mr_active;
      seenActive_q <= seenActive_d;
      shDir_q      <= shDir_d;
      rrPtr_q      <= rrPtr_d;
      cmdErr_q     <= cmdErr_d;
      shDiv_q      <= shDiv_d;
      shSteps_q    <= shSteps_d;
      mrDiv_q      <= mrDiv_d;
      mrSteps_q    <= mrSteps_d;
      timer_q      <= timer_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gOut
    assign mr_divider[g*DIV_W +: DIV_W]  = mrDiv_q[g];
    assign mr_steps[g*STEP_W +: STEP_W]  = mrSteps_q[g];
  end

  assign mr_dir   = mrDir_q;
  assign mr_reset = mrReset_q;
  assign pending  = pending_q;
  assign busy     = busy_q;
  assign aborted  = aborted_q;
  assign fault    = fault_q;
  assign cmd_err  = cmdErr_q;

endmodule

// File: doc/motor_cmd_scheduler.md
# motor_cmd_scheduler

Per-channel command scheduler between the UART command parser and the ten `motorCtrlSimple_v2` step generators. It accepts parsed move commands (channel, divider, step count, direction), holds one shadow command per channel, and loads it into the motor controller only once that controller is idle. It also aborts moves driving into an active endstop, and exports pending/busy/abort/fault status for the UART status reporter.

## Interface
- `NUM_CH`, 10, number of motor channels (1..15)
- `DIV_W`, 16, divider width
- `STEP_W`, 11, step-count width
- `HOME_DIR`, 0, `mr_dir` value that moves toward the endstop
- `START_TO`, 16, cycles allowed between load and `mr_active` rising

Ports:
- `CLOCK_25`  in  1  system clock, 25 MHz
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready` at a rising edge
- `cmd_ch`  in  4  target channel
- `cmd_div`  in  DIV_W  step divider
- `cmd_steps`  in  STEP_W  steps to go
- `cmd_dir`  in  1  direction
- `cmd_err`  out  1  one-cycle pulse: command dropped
- `mr_active`  in  NUM_CH  `activeMode` from each motor controller
- `term_n`  in  NUM_CH  raw endstop inputs, active low, asynchronous
- `mr_divider`  out  NUM_CH*DIV_W  per-channel divider, channel i at `[i*DIV_W +: DIV_W]`
- `mr_steps`  out  NUM_CH*STEP_W  per-channel stepsToGo
- `mr_dir`  out  NUM_CH  per-channel direction
- `mr_reset`  out  NUM_CH  one-cycle abort pulse to the motor controller
- `pending`  out  NUM_CH  shadow slot full
- `busy`  out  NUM_CH  command loaded and not yet finished
- `aborted`  out  NUM_CH  sticky: last move aborted by endstop
- `fault`  out  NUM_CH  sticky: motor never started within `START_TO`

## Operation
- Reset: all outputs and registers are 0, including the RR pointer and `cmd_err`.
- `term_n` passes through a 2-flop synchronizer. `hit[i] = ~term_sync[i]`.
- Ready is combinational: `cmd_ready = (cmd_ch >= NUM_CH) | ~pending[cmd_ch]`.
- Accept with `cmd_ch >= NUM_CH` or `cmd_steps == 0`:
  - command is dropped
  - `cmd_err` pulses
  - no other state changes.
- Valid accept:
  - shadow[ch] <= {div, steps, dir}
  - `pending[ch]` <= 1
  - `aborted[ch]` <= 0 and `fault[ch]` <= 0.
- Eligibility: channel i is eligible when `pending[i] & ~busy[i] & ~mr_active[i]`.
- Load arbiter:
  - one load per cycle, round-robin over eligible channels, starting at the RR pointer
  - the granted channel g copies its shadow to `mr_divider[g]`, `mr_steps[g]` and `mr_dir[g]`
  - `pending[g]` <= 0, `busy[g]` <= 1, start timer[g] <= `START_TO`
  - RR pointer <= g+1, wrapping from `NUM_CH-1` to 0.
- Per busy channel, evaluated in priority order:
  1. Abort: `hit[i]` and `mr_dir[i]==HOME_DIR`. Result: `mr_reset[i]` pulses, `mr_steps[i]` <= 0, `busy[i]` <= 0, `pending[i]` <= 0, `aborted[i]` <= 1.
  2. Done: `mr_active` falling edge (registered previous value 1, current 0). Result: `mr_steps[i]` <= 0, `busy[i]` <= 0.
  3. Start timeout: timer reaches 0 and `mr_active[i]` has never been seen high since load. Result: `mr_steps[i]` <= 0, `busy[i]` <= 0, `fault[i]` <= 1.
- `mr_divider` and `mr_dir` hold their values after completion. Only `mr_steps` is zeroed, so the controller does not restart.
- `hit` on a non-busy channel has no effect. Pending commands toward the endstop still load, then abort on the next cycle.

## Timing
- Accept at edge N: `pending` is high from N+1, the earliest load is edge N+1, and `busy` and `mr_*` update from N+2.
- Load to `mr_active` rise depends on the controller. Timer counts down once per cycle from the load edge.
- `mr_reset` is high for exactly one cycle, in the cycle after abort detection.
- Endstop latency: `term_n` falling to `mr_reset` high is 3 edges (2 sync + 1 register).
- Same-edge events on one channel:
  - abort beats done and timeout
  - a new valid accept in the abort cycle survives: `pending` is set and `aborted` stays 0, because the accept wins.
- A load and an accept never collide on the same channel, since `cmd_ready` is low while `pending` is set.
- A reset mid-move clears `busy` and zeroes `mr_steps` immediately (asynchronous).

## Test plan
- **Single move:** accept ch 3, div 0x0100, steps 5, dir 1; `mr_active[3]` high 2 cycles after load and low later. Expect `pending[3]` for 1 cycle, then `busy[3]` and `mr_steps[3]` = 5; on the active fall `mr_steps[3]` = 0 and `busy[3]` = 0.
- **Backpressure:** with ch 2 busy, accept one command to ch 2, then offer a second. Expect `cmd_ready` = 0 until the first load happens after the active fall; the second command loads only after the first completes.
- **Round-robin:** accept commands for ch 0, 5 and 9 back-to-back while all are idle. Expect loads on consecutive cycles in order 0, 5, 9; with the pointer at 6 and ch 0 and 9 eligible, expect 9 then 0.
- **Endstop abort:** ch 1 busy with dir = `HOME_DIR`, drive `term_n[1]` low. Expect `mr_reset[1]` as a 1-cycle pulse 3 edges later, `mr_steps[1]` = 0, `aborted[1]` = 1. Repeat with dir = 1: no abort.
- **Errors and timeout:**
  - accept ch 12 → `cmd_err` pulse, no state change
  - accept steps = 0 → `cmd_err` pulse, no state change
  - load ch 4 with `mr_active` held low → `fault[4]` = 1 and `busy[4]` = 0 after 16 cycles.
- **Reset mid-move:** deassert `rst_n` while ch 0 is busy and ch 1 is pending. Expect all status and `mr_steps` to be 0 asynchronously, and `cmd_ready` = 1 after release.
